loadq_pipe_sel: RTL
===================

// Module: loadq_pipe_sel
// PURPOSE
//  Selects one LDQ entry per cycle from the per-entry pipe requests (e_pipe_req_mm0) and presents
//  it as the single load-queue request to the memory-pipe arbiter in mm0. Returns the arbiter's
//  grant to exactly the selected entry in the same cycle (e_pipe_gnt_mm0).
//  Sits between the loadq_entry array and the mempipe arbiter.
//  Provides request locking, round-robin fairness and a starvation escalation flag.
// PARAMETERS
//  LDQ_NUM_ENTRIES  8   number of load queue entries (power of 2, >=2)
//  STARVE_THRESH    15  consecutive un-granted request cycles before ldq_starve_mm0 asserts (1..255)
// PORTS
//  clk                 in   1                  clock
//  reset               in   1                  reset, synchronous, active-high
//  nuke_rb1_valid      in   1                  pipeline nuke; drops lock/starve state
//  e_pipe_req_mm0      in   LDQ_NUM_ENTRIES    per-entry pipe request
//  e_pipe_req_pkt_mm0  in   [N] t_mempipe_arb  per-entry request packet
//  e_pipe_gnt_mm0      out  LDQ_NUM_ENTRIES    per-entry grant, one-hot or zero
//  ldq_req_mm0         out  1                  aggregated LDQ request to mempipe arbiter
//  ldq_req_pkt_mm0     out  t_mempipe_arb      packet of selected entry ('0 when no request)
//  ldq_starve_mm0      out  1                  priority escalation hint to mempipe arbiter
//  ldq_gnt_mm0         in   1                  arbiter grant for ldq_req_mm0, same cycle
// BEHAVIOUR
//  - State: rr_ptr (clog2 N bits), lock_vld, lock_id, starve_cnt (8 bits). All are reset to 0.
//  - Selection (combinational, mm0):
//      lock_vld & e_pipe_req_mm0[lock_id] -> sel = lock_id.
//      Otherwise sel = first requesting entry found scanning from rr_ptr upward, wrapping at N-1 -> 0.
//  - ldq_req_mm0 = |e_pipe_req_mm0. ldq_req_pkt_mm0 = e_pipe_req_pkt_mm0[sel], else '0.
//  - e_pipe_gnt_mm0[i] = ldq_gnt_mm0 & ldq_req_mm0 & (sel==i).
//      ldq_gnt_mm0 without ldq_req_mm0 is ignored; no grant is produced.
//  - Request taken (req & gnt): rr_ptr <= sel+1 (mod N), lock_vld <= 0, starve_cnt <= 0.
//  - Request stalled (req & ~gnt): lock_vld <= 1, lock_id <= sel.
//      starve_cnt <= sat(starve_cnt+1, 255).
//      The packet presented to the arbiter therefore stays stable until it is granted.
//  - Locked entry drops its request (e.g. its stq elders became valid): lock ignored that cycle.
//      Selection falls to round robin. lock_vld <= 0 unless the new sel stalls.
//      starve_cnt is not cleared by the drop.
//  - No request: lock_vld <= 0, starve_cnt <= 0, rr_ptr holds.
//  - ldq_starve_mm0 = ldq_req_mm0 & (starve_cnt >= STARVE_THRESH). Registered count, combinational qual.
//  - nuke_rb1_valid: next cycle lock_vld=0 and starve_cnt=0; rr_ptr holds.
//      Takes priority over a stall update in the same cycle.
//      A grant coincident with the nuke still passes through and still advances rr_ptr.
//  - reset: all state cleared and all outputs 0 from the cycle after reset is sampled.
//      During the reset cycle e_pipe_gnt_mm0 is forced to 0.
//  - Zero added latency: request to grant path is purely combinational within mm0.
//  - Assertions:
//      e_pipe_gnt_mm0 is onehot0.
//      A grant is only given to a requesting entry.
//      Under lock, ldq_req_pkt_mm0 stays stable while the locked entry keeps requesting.
// TESTING
//  1. Reset; req=8'h00 -> ldq_req_mm0=0, gnt=0, pkt='0, ldq_starve_mm0=0.
//  2. req=8'b1000_0101, gnt=1 every cycle, rr_ptr=0 -> grants go to entry 0, 2, 7, 0 in successive cycles.
//  3. req=8'h06, gnt=0 for 3 cycles, then entry 2's request is kept -> entry 1 stays selected.
//       Then gnt=1 -> e_pipe_gnt=8'h02 and rr_ptr=2.
//  4. Entry 3 locked, its request drops, entry 5 is requesting
//       -> sel=5 in the same cycle; lock_id=5 if entry 5 stalls.
//  5. STARVE_THRESH=15, req held with gnt=0 for 15 cycles -> ldq_starve_mm0=1 on cycle 16.
//       Then gnt=1 -> starve flag=0 the next cycle.
//  6. Locked and starving, then nuke_rb1_valid=1 -> next cycle lock_vld=0, starve=0, rr_ptr unchanged.
//       Also repeat with reset asserted mid-lock -> all state clears.

Source files
------------

// File: rtl/loadq_pipe_sel_if.sv
// Connection between the LDQ entry array / mempipe arbiter and the pipe selector.
// The slave side is the selector; the master side drives entry requests and the arbiter grant.
interface loadq_pipe_sel_if #(
  parameter int LDQ_NUM_ENTRIES = 8,
  parameter int PKT_W           = 16
);
  logic                                  nuke_rb1_valid;
  logic [LDQ_NUM_ENTRIES-1:0]            e_pipe_req_mm0;
  logic [LDQ_NUM_ENTRIES-1:0][PKT_W-1:0] e_pipe_req_pkt_mm0;
  logic [LDQ_NUM_ENTRIES-1:0]            e_pipe_gnt_mm0;
  logic                                  ldq_req_mm0;
  logic [PKT_W-1:0]                      ldq_req_pkt_mm0;
  logic                                  ldq_starve_mm0;
  logic                                  ldq_gnt_mm0;

  modport master (
    output nuke_rb1_valid, e_pipe_req_mm0, e_pipe_req_pkt_mm0, ldq_gnt_mm0,
    input  e_pipe_gnt_mm0, ldq_req_mm0, ldq_req_pkt_mm0, ldq_starve_mm0
  );

  modport slave (
    input  nuke_rb1_valid, e_pipe_req_mm0, e_pipe_req_pkt_mm0, ldq_gnt_mm0,
    output e_pipe_gnt_mm0, ldq_req_mm0, ldq_req_pkt_mm0, ldq_starve_mm0
  );
endinterface

// File: rtl/loadq_pipe_sel.sv
// Picks one LDQ entry per cycle for the mempipe arbiter: lock-until-granted on stall,
// round-robin otherwise, with a saturating starvation counter feeding an escalation hint.
module loadq_pipe_sel #(
  parameter int LDQ_NUM_ENTRIES = 8,
  parameter int STARVE_THRESH   = 15,
  parameter int PKT_W           = 16
) (
  input logic              clk,
  input logic              reset,
  loadq_pipe_sel_if.slave  lq
);
  localparam int IDW = $clog2(LDQ_NUM_ENTRIES);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] lock_id;
  logic           lock_vld;
  logic [7:0]     starve_cnt;
  logic [IDW-1:0] sel;
  logic           req_any;

  assign req_any = |lq.e_pipe_req_mm0;

  // Lock wins only while the locked entry still requests; otherwise scan from rr_ptr with wrap.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    sel   = rr_ptr;
    found = 1'b0;
    idx   = '0;
    if (lock_vld && lq.e_pipe_req_mm0[lock_id]) begin
      sel = lock_id;
    end else begin
      for (int k = 0; k < LDQ_NUM_ENTRIES; k++) begin
        idx = rr_ptr + IDW'(k);
        if (!found && lq.e_pipe_req_mm0[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign lq.ldq_req_mm0     = req_any;
  assign lq.ldq_req_pkt_mm0 = req_any ? lq.e_pipe_req_pkt_mm0[sel] : '0;
  assign lq.e_pipe_gnt_mm0  = (!reset && lq.ldq_gnt_mm0 && req_any)
                              ? (LDQ_NUM_ENTRIES'(1) << sel) : '0;
  assign lq.ldq_starve_mm0  = req_any && (starve_cnt >= 8'(STARVE_THRESH));

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      lock_id    <= '0;
      lock_vld   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (req_any) begin
        if (lq.ldq_gnt_mm0) begin
          rr_ptr     <= sel + 1'b1;
          lock_vld   <= 1'b0;
          starve_cnt <= '0;
        end else begin
          lock_vld <= 1'b1;
          lock_id  <= sel;
          if (starve_cnt != 8'hff) starve_cnt <= starve_cnt + 8'd1;
        end
      end else begin
        lock_vld   <= 1'b0;
        starve_cnt <= '0;
      end
      // Nuke overrides any stall update but leaves the grant-driven rr_ptr advance intact.
      if (lq.nuke_rb1_valid) begin
        lock_vld   <= 1'b0;
        starve_cnt <= '0;
      end
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) $onehot0(lq.e_pipe_gnt_mm0));
  a_gnt_to_req:  assert property (@(posedge clk)
                   (lq.e_pipe_gnt_mm0 & ~lq.e_pipe_req_mm0) == '0);
  a_lock_stable: assert property (@(posedge clk) disable iff (reset)
                   (lock_vld && lq.e_pipe_req_mm0[lock_id])
                   |-> lq.ldq_req_pkt_mm0 == $past(lq.ldq_req_pkt_mm0));
endmodule
